// File: rtl/udp_tx.sv
// UDP transmit encapsulation: prepends the 8-byte UDP header, then passes the payload through with no added latency.
// Optional build macro UDP_TX_LEN_CHECK_EN: cross-checks last_i against the byte counter and aborts the frame on a mismatch.
module udp_tx #(
  parameter int                DATA_W   = 16,
  parameter int                LEN_W    = $clog2(DATA_W/8),
  parameter int                PORT_W   = 16,
  parameter logic [PORT_W-1:0] SRC_PORT = 16'd18070,
  parameter logic [PORT_W-1:0] DST_PORT = 16'd18070
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cancel_i,
  input  logic              valid_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              last_i,
  input  logic [15:0]       pay_len_i,
  output logic              ready_o,
  input  logic              ready_i,
  output logic              valid_o,
  output logic              start_o,
  output logic              last_o,
  output logic [DATA_W-1:0] data_o,
  output logic [LEN_W-1:0]  len_o,
  output logic [15:0]       udp_len_o,
  output logic              cancel_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    HEAD = 3'b010,
    DATA = 3'b100
  } state_t;

  state_t       state, state_nxt;
  logic [1:0]   head_cnt;
  logic [15:0]  byte_cnt;
  logic [15:0]  pay_len;
  logic [15:0]  udp_len;
  logic [15:0]  head_word;
  logic [16:0]  beat_bytes;
  logic [16:0]  byte_sum;
  logic         pay_end;
  logic         head_adv;
  logic         data_acc;

  // Header fields go out in network byte order: low byte travels in the upper lane.
  function automatic logic [15:0] net16(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

`ifndef UDP_TX_LEN_CHECK_EN
  logic unused_last;
  assign unused_last = last_i;
`endif

  assign udp_len_o  = udp_len;
  assign beat_bytes = (len_i == '0) ? 17'd2 : 17'd1;
  assign byte_sum   = {1'b0, byte_cnt} + beat_bytes;
  assign pay_end    = (byte_sum >= {1'b0, pay_len});

  always_comb begin
    case (head_cnt)
      2'd0:    head_word = net16(SRC_PORT);
      2'd1:    head_word = net16(DST_PORT);
      2'd2:    head_word = net16(udp_len);
      default: head_word = 16'h0000;
    endcase
  end

  always_comb begin
    state_nxt = state;
    valid_o   = 1'b0;
    ready_o   = 1'b0;
    start_o   = 1'b0;
    last_o    = 1'b0;
    data_o    = '0;
    len_o     = '0;
    cancel_o  = 1'b0;
    err_o     = 1'b0;
    head_adv  = 1'b0;
    data_acc  = 1'b0;
    unique case (state)
      IDLE: begin
        if (valid_i && start_i) state_nxt = HEAD;
      end
      HEAD: begin
        valid_o = 1'b1;
        data_o  = head_word;
        start_o = (head_cnt == 2'd0);
        last_o  = (head_cnt == 2'd3) && (pay_len == 16'd0);
        if (cancel_i) begin
          cancel_o  = 1'b1;
          state_nxt = IDLE;
        end else if (ready_i) begin
          head_adv = 1'b1;
          if (head_cnt == 2'd3) state_nxt = (pay_len == 16'd0) ? IDLE : DATA;
        end
      end
      DATA: begin
        valid_o = valid_i;
        ready_o = ready_i;
        data_o  = data_i;
        len_o   = len_i;
        last_o  = valid_i && pay_end;
        if (cancel_i) begin
          cancel_o  = 1'b1;
          state_nxt = IDLE;
        end else if (valid_i && ready_i) begin
          data_acc = 1'b1;
          if (pay_end) state_nxt = IDLE;
`ifdef UDP_TX_LEN_CHECK_EN
          if (last_i != pay_end) begin
            err_o     = 1'b1;
            cancel_o  = 1'b1;
            state_nxt = IDLE;
          end
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      head_cnt <= 2'd0;
      byte_cnt <= 16'd0;
      udp_len  <= 16'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && valid_i && start_i) begin
        udp_len  <= pay_len_i + 16'd8;
        head_cnt <= 2'd0;
        byte_cnt <= 16'd0;
      end else if (state_nxt == IDLE) begin
        head_cnt <= 2'd0;
        byte_cnt <= 16'd0;
      end else begin
        if (head_adv) head_cnt <= head_cnt + 2'd1;
        if (data_acc) byte_cnt <= byte_sum[15:0];
      end
    end
  end

  // Payload length is datapath state, captured with the start beat only.
  always_ff @(posedge clk) begin
    if (state == IDLE && valid_i && start_i) pay_len <= pay_len_i;
  end

endmodule
